// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types, constants and helpers for the keypad debouncer.
//               Key index map used throughout: 0..9 = num_raw bits,
//               10 = ctrl_raw[0] (right), 11 = ctrl_raw[1] (left).
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  localparam logic [3:0] KEY_LEFT  = 4'd10;
  localparam logic [3:0] KEY_RIGHT = 4'd11;

  localparam int DB_CYCLES_DEFAULT     = 20;
  localparam int REPEAT_DELAY_DEFAULT  = 500;
  localparam int REPEAT_PERIOD_DEFAULT = 100;

  localparam int NUM_KEYS = 12;

  // True when exactly one bit of the key vector is set.
  function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
    return (v != '0) && ((v & (v - 12'd1)) == '0);
  endfunction

  // Index of the highest set bit; only meaningful for a one-hot vector.
  function automatic logic [3:0] key_index(input logic [NUM_KEYS-1:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Key index to reported code: bit0 is digit 0, bit1..bit9 are digits 9..1.
  function automatic logic [3:0] key_code_of(input logic [3:0] idx);
    logic [3:0] code;
    if (idx == 4'd0)       code = 4'd0;
    else if (idx <= 4'd9)  code = 4'd10 - idx;
    else if (idx == 4'd10) code = KEY_RIGHT;
    else                   code = KEY_LEFT;
    return code;
  endfunction

  // Saturating 16-bit increment so counters can never wrap.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage : keypad_pkg
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : Two-flop synchronizer bank, synchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two-stage capture of the asynchronous inputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule : sync2
`default_nettype wire

// File: rtl/keypad_debounce.sv
`default_nettype none
// ============================================================================
// Module      : keypad_debounce
// Description : Debounces a 10-digit + 2-cursor keypad. Accepts a key only
//               when it is the sole key held for DB_CYCLES synced samples,
//               then reports a one-hot level, a key code and a valid pulse.
//               Optional auto-repeat enabled by defining KEY_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DB_CYCLES     = DB_CYCLES_DEFAULT,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEFAULT,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] num_raw,
  input  logic [1:0] ctrl_raw,
  output logic [9:0] number_btn,
  output logic [1:0] control_btn,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam logic [15:0] C_DB_LAST = 16'(DB_CYCLES - 1);

  if (DB_CYCLES < 2 || DB_CYCLES > 65535 ||
      REPEAT_DELAY < 2 || REPEAT_DELAY > 65535 ||
      REPEAT_PERIOD < 2 || REPEAT_PERIOD > 65535) begin : g_param_check
    $error("keypad_debounce: parameter out of range");
  end

  logic [NUM_KEYS-1:0] w_keys;
  logic [NUM_KEYS-1:0] w_cap_mask;
  logic                w_cap_high;
  logic                w_only_cap;
  logic                w_any;

  state_t              r_state;
  logic [15:0]         r_cnt;
  logic [3:0]          r_idx;
  logic [NUM_KEYS-1:0] r_btn;
  logic                r_valid;
  logic [3:0]          r_code;

  sync2 #(
    .WIDTH (NUM_KEYS)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d ({ctrl_raw, num_raw}),
    .o_q (w_keys)
  );

  assign w_cap_mask = 12'd1 << r_idx;
  assign w_cap_high = w_keys[r_idx];
  assign w_only_cap = (w_keys == w_cap_mask);
  assign w_any      = |w_keys;

`ifdef KEY_REPEAT_EN
  logic [15:0] r_rpt_cnt;
  logic        r_rpt_first;
  logic [15:0] w_rpt_last;

  // Cycles from one accept to the next: first the delay, then the period.
  assign w_rpt_last = r_rpt_first ? 16'(REPEAT_DELAY - 1) : 16'(REPEAT_PERIOD - 1);
`endif

  // Debounce state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_btn   <= '0;
      r_valid <= 1'b0;
      r_code  <= '0;
`ifdef KEY_REPEAT_EN
      r_rpt_cnt   <= '0;
      r_rpt_first <= 1'b1;
`endif
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (is_onehot(w_keys)) begin
            r_idx   <= key_index(w_keys);
            r_cnt   <= '0;
            r_state <= ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (!w_only_cap) begin
            r_state <= ST_IDLE;
          end else if (r_cnt == C_DB_LAST) begin
            r_state <= ST_HELD;
            r_btn   <= w_cap_mask;
            r_valid <= 1'b1;
            r_code  <= key_code_of(r_idx);
`ifdef KEY_REPEAT_EN
            r_rpt_cnt   <= '0;
            r_rpt_first <= 1'b1;
`endif
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end
        ST_HELD: begin
          // Only the captured key matters here; other keys are ignored.
          if (!w_cap_high) begin
            r_btn   <= '0;
            r_cnt   <= '0;
            r_state <= ST_RELEASE;
          end
`ifdef KEY_REPEAT_EN
          else if (r_rpt_cnt == w_rpt_last) begin
            r_btn       <= w_cap_mask;
            r_valid     <= 1'b1;
            r_rpt_cnt   <= '0;
            r_rpt_first <= 1'b0;
          end else begin
            // One-cycle low gap right before each repeat accept.
            if (r_rpt_cnt == w_rpt_last - 16'd1) r_btn <= '0;
            r_rpt_cnt <= sat_inc(r_rpt_cnt);
          end
`endif
        end
        ST_RELEASE: begin
          if (w_any) begin
            r_cnt <= '0;
          end else if (r_cnt == C_DB_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= sat_inc(r_cnt);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign number_btn  = r_btn[9:0];
  assign control_btn = r_btn[11:10];
  assign key_valid   = r_valid;
  assign key_code    = r_code;

endmodule : keypad_debounce
`default_nettype wire

// File: tb/tb_keypad_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_debounce
// Description : Directed self-checking bench for keypad_debounce with a
//               scoreboard of expected accept events (cycle, code, level).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_debounce;
  import keypad_pkg::*;

  logic       clk;
  logic       rst;
  logic [9:0] num_raw;
  logic [1:0] ctrl_raw;
  logic [9:0] number_btn;
  logic [1:0] control_btn;
  logic       key_valid;
  logic [3:0] key_code;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         cyc;
    logic [3:0] code;
    logic [11:0] btn;
  } exp_t;

  exp_t sb[$];

  keypad_debounce #(
    .DB_CYCLES     (4),
    .REPEAT_DELAY  (20),
    .REPEAT_PERIOD (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .num_raw     (num_raw),
    .ctrl_raw    (ctrl_raw),
    .number_btn  (number_btn),
    .control_btn (control_btn),
    .key_valid   (key_valid),
    .key_code    (key_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int c, input logic [3:0] code, input logic [11:0] btn);
    exp_t e;
    e.cyc  = c;
    e.code = code;
    e.btn  = btn;
    sb.push_back(e);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Scoreboard side: every valid pulse must match the oldest expected accept.
  always @(negedge clk) begin
    exp_t e;
    check("onehot_out", 32'($countones({control_btn, number_btn}) <= 1), 32'd1);
    if (rst && key_valid) begin
      check("valid_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("valid_cycle", 32'(cyc), 32'(e.cyc));
        check("valid_code", 32'(key_code), 32'(e.code));
        check("valid_level", 32'({control_btn, number_btn}), 32'(e.btn));
      end
    end
  end

  initial begin
    int n;
    int m;
    num_raw  = '0;
    ctrl_raw = '0;
    rst      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_number_btn", 32'(number_btn), 32'd0);
    check("rst_control_btn", 32'(control_btn), 32'd0);
    check("rst_key_valid", 32'(key_valid), 32'd0);
    check("rst_key_code", 32'(key_code), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Clean press of digit '1' (bit 9), held 30 cycles.
    n = cyc;
    num_raw = 10'b10_0000_0000;
    push_exp(n + 7, 4'd1, 12'h200);
`ifdef KEY_REPEAT_EN
    push_exp(n + 27, 4'd1, 12'h200);
`endif
    wait_to(n + 6);
    check("clean_before", 32'(number_btn), 32'd0);
    wait_to(n + 7);
    check("clean_level", 32'(number_btn), 32'h200);
    check("clean_code", 32'(key_code), 32'd1);
    wait_to(n + 8);
    check("clean_pulse_once", 32'(key_valid), 32'd0);
    wait_to(n + 30);
    num_raw = '0;
    wait_to(n + 32);
    check("clean_still_high", 32'(number_btn), 32'h200);
    wait_to(n + 33);
    check("clean_release", 32'(number_btn), 32'd0);
    check("clean_code_holds", 32'(key_code), 32'd1);
    wait_to(n + 42);

    // Bouncing left key, then stable.
    n = cyc;
    for (int i = 0; i < 12; i++) begin
      ctrl_raw = (((i / 2) % 2) == 0) ? 2'b10 : 2'b00;
      @(negedge clk);
    end
    ctrl_raw = 2'b10;
    push_exp(n + 19, KEY_LEFT, 12'h800);
    wait_to(n + 18);
    check("bounce_before", 32'(control_btn), 32'd0);
    wait_to(n + 19);
    check("bounce_level", 32'(control_btn), 32'b10);
    check("bounce_code", 32'(key_code), 32'd10);
    wait_to(n + 25);
    ctrl_raw = '0;
    wait_to(n + 40);

    // Two keys together, then one dropped, then a second key during HELD.
    n = cyc;
    num_raw = 10'b00_0010_0001;
    wait_to(n + 12);
    check("two_keys_none", 32'({control_btn, number_btn}), 32'd0);
    m = cyc;
    num_raw = 10'b00_0000_0001;
    push_exp(m + 7, 4'd0, 12'h001);
    wait_to(m + 6);
    check("two_keys_before", 32'(number_btn), 32'd0);
    wait_to(m + 7);
    check("two_keys_bit0", 32'(number_btn), 32'd1);
    check("two_keys_code", 32'(key_code), 32'd0);
    wait_to(m + 10);
    ctrl_raw = 2'b01;
    wait_to(m + 20);
    check("held_ignore_num", 32'(number_btn), 32'd1);
    check("held_ignore_ctrl", 32'(control_btn), 32'd0);
    ctrl_raw = '0;
    num_raw  = '0;
    wait_to(m + 35);

    // Reset while HELD, key stays down and is re-accepted.
    n = cyc;
    num_raw = 10'b00_0000_1000;
    push_exp(n + 7, 4'd7, 12'h008);
    wait_to(n + 7);
    check("pre_rst_level", 32'(number_btn), 32'h8);
    check("pre_rst_code", 32'(key_code), 32'd7);
    wait_to(n + 12);
    rst = 1'b0;
    wait_to(n + 13);
    check("midrst_level", 32'({control_btn, number_btn}), 32'd0);
    check("midrst_code", 32'(key_code), 32'd0);
    check("midrst_valid", 32'(key_valid), 32'd0);
    rst = 1'b1;
    push_exp(n + 20, 4'd7, 12'h008);
    wait_to(n + 19);
    check("reaccept_before", 32'(number_btn), 32'd0);
    wait_to(n + 20);
    check("reaccept_level", 32'(number_btn), 32'h8);
    wait_to(n + 25);
    num_raw = '0;
    wait_to(n + 40);

    // Long hold: 60 cycles.
    n = cyc;
    num_raw = 10'b10_0000_0000;
    push_exp(n + 7, 4'd1, 12'h200);
`ifdef KEY_REPEAT_EN
    for (int k = 0; k < 5; k++) push_exp(n + 27 + 8 * k, 4'd1, 12'h200);
`endif
    wait_to(n + 25);
    check("hold_level_25", 32'(number_btn), 32'h200);
    wait_to(n + 26);
`ifdef KEY_REPEAT_EN
    check("hold_gap_26", 32'(number_btn), 32'd0);
`else
    check("hold_gap_26", 32'(number_btn), 32'h200);
`endif
    wait_to(n + 27);
    check("hold_level_27", 32'(number_btn), 32'h200);
    wait_to(n + 60);
    num_raw = '0;
    wait_to(n + 62);
    check("hold_level_62", 32'(number_btn), 32'h200);
    wait_to(n + 63);
    check("hold_release", 32'(number_btn), 32'd0);
    wait_to(n + 72);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_keypad_debounce
`default_nettype wire
